// File: rtl/sign_narrower.sv
// ---------------------------------------------------------------------------
// sign_narrower
//
// Narrows a signed 32-bit word to a signed 16-bit result. The result is
// buffered in a 2-entry FIFO with valid/ready handshakes on both sides. The
// block also keeps a saturating count of accepted words that did not fit.
//
// A word that fits in signed 16 bits (in_data[31:15] all equal) passes
// through as in_data[15:0]. A word that does not fit is either truncated
// (sat_mode=0) or clamped to 16'h7FFF / 16'h8000 by sign (sat_mode=1).
// out_ovf flags the words that did not fit.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high reset
//   in_valid   producer offers in_data this cycle
//   in_ready   block can accept a word (FIFO holds fewer than 2 entries)
//   in_data    signed 32-bit word to narrow
//   sat_mode   0 = truncate, 1 = saturate; sampled together with in_data
//   out_valid  out_data/out_ovf hold a result
//   out_ready  consumer takes the result this cycle
//   out_data   signed 16-bit narrowed result (oldest FIFO entry)
//   out_ovf    source word was not representable in signed 16 bits
//   clr_count  synchronous clear of ovf_count (wins over an increment)
//   ovf_count  saturating count of accepted overflowing words
// ---------------------------------------------------------------------------
module sign_narrower (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        sat_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  input  logic        clr_count,
  output logic [7:0]  ovf_count
);

  // Narrowing datapath
  logic        upper_ones;
  logic        upper_zeros;
  logic        ovf;
  logic [15:0] result;

  // The word fits only when bits 31..15 are a pure sign extension
  // (all ones or all zeros).
  always_comb begin
    upper_ones  = &in_data[31:15];
    upper_zeros = ~|in_data[31:15];
    ovf         = ~(upper_ones | upper_zeros);
    result      = in_data[15:0];
    if (ovf && sat_mode) begin
      result = in_data[31] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Two-entry FIFO
  logic [15:0] data_mem [2];
  logic        ovf_mem  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // in_ready depends only on occupancy. It must not look at out_ready,
  // so a full FIFO refuses a word even while it is being drained.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;

  // A pop on an empty FIFO cannot happen: out_valid gates it. A push into
  // an empty FIFO therefore only grows occupancy to 1.
  assign pop       = out_valid & out_ready;

  // The head is read straight from storage. Reset clears the storage, so
  // out_data/out_ovf read as zero while reset is held.
  assign out_data  = data_mem[rd_ptr];
  assign out_ovf   = ovf_mem[rd_ptr];

  // Pointer/occupancy bookkeeping and storage writes. With one entry held,
  // a simultaneous push and pop advances both pointers. The new word then
  // becomes the head and occupancy stays at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      data_mem[0] <= 16'h0000;
      data_mem[1] <= 16'h0000;
      ovf_mem[0]  <= 1'b0;
      ovf_mem[1]  <= 1'b0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= result;
        ovf_mem[wr_ptr]  <= ovf;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Overflow counter. A clear wins over an increment in the same cycle.
  // The count holds at 255 instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= 8'd0;
    end else if (clr_count) begin
      ovf_count <= 8'd0;
    end else if (push && ovf && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sign_narrower.sv
// ---------------------------------------------------------------------------
// tb_sign_narrower
//
// Directed-vector bench for sign_narrower. The bench drives inputs 1 time
// unit after a rising edge and samples outputs at that same offset. Every
// expected value is computed by hand and written as a constant below.
// ---------------------------------------------------------------------------
module tb_sign_narrower;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sat_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        clr_count;
  logic [7:0]  ovf_count;

  int checkCount = 0;
  int errorCount = 0;

  sign_narrower dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sat_mode  (sat_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop the run if it wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value against its expected value and counts it
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Offers one word and waits, for a bounded time, until it is accepted.
  // The task returns 1 unit after the accepting edge with in_valid low.
  task automatic applyStimulus(input logic [31:0] d, input logic s);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    sat_mode = s;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Pops the head entry with a one-cycle out_ready pulse
  task automatic popOne();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    sat_mode  = 1'b0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst_out_data",  {16'd0, out_data},  32'h0);
    checkOutput("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    checkOutput("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fit check: both boundary words are representable
    applyStimulus(32'h00007FFF, 1'b0);
    checkOutput("fit1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("fit1_data",  {16'd0, out_data},  32'h7FFF);
    checkOutput("fit1_ovf",   {31'd0, out_ovf},   32'd0);
    applyStimulus(32'hFFFF8000, 1'b1);
    checkOutput("fit_full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fit_head_held",  {16'd0, out_data}, 32'h7FFF);
    popOne();
    checkOutput("fit2_data",  {16'd0, out_data},  32'h8000);
    checkOutput("fit2_ovf",   {31'd0, out_ovf},   32'd0);
    popOne();
    checkOutput("fit_empty",  {31'd0, out_valid}, 32'd0);
    checkOutput("fit_count",  {24'd0, ovf_count}, 32'd0);

    // Saturate versus truncate
    applyStimulus(32'h00012345, 1'b1);
    checkOutput("sat_pos_data", {16'd0, out_data}, 32'h7FFF);
    checkOutput("sat_pos_ovf",  {31'd0, out_ovf},  32'd1);
    popOne();
    applyStimulus(32'h00012345, 1'b0);
    checkOutput("trunc_data", {16'd0, out_data}, 32'h2345);
    checkOutput("trunc_ovf",  {31'd0, out_ovf},  32'd1);
    popOne();
    applyStimulus(32'hFFFE0000, 1'b1);
    checkOutput("sat_neg_data", {16'd0, out_data}, 32'h8000);
    checkOutput("sat_neg_ovf",  {31'd0, out_ovf},  32'd1);
    popOne();
    checkOutput("sat_count3", {24'd0, ovf_count}, 32'd3);
    // Just outside the range: only bit 15 disagrees with the upper bits
    applyStimulus(32'hFFFF7FFF, 1'b1);
    checkOutput("edge_neg_data", {16'd0, out_data}, 32'h8000);
    checkOutput("edge_neg_ovf",  {31'd0, out_ovf},  32'd1);
    popOne();
    applyStimulus(32'h00008000, 1'b0);
    checkOutput("edge_pos_data", {16'd0, out_data}, 32'h8000);
    checkOutput("edge_pos_ovf",  {31'd0, out_ovf},  32'd1);
    popOne();
    checkOutput("sat_count5", {24'd0, ovf_count}, 32'd5);

    // Backpressure: three words are offered back-to-back while the consumer stalls
    in_valid = 1'b1;
    sat_mode = 1'b0;
    in_data  = 32'h00000011;
    @(posedge clk); #1;
    checkOutput("bp_valid1", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_ready1", {31'd0, in_ready},  32'd1);
    in_data = 32'hFFFFFF22;
    @(posedge clk); #1;
    checkOutput("bp_ready2", {31'd0, in_ready},  32'd0);
    checkOutput("bp_head2",  {16'd0, out_data},  32'h0011);
    in_data = 32'h00000033;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_held_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_held_head",  {16'd0, out_data}, 32'h0011);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_drain1_data",  {16'd0, out_data}, 32'hFF22);
    checkOutput("bp_drain1_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_drain2_data",  {16'd0, out_data},  32'h0033);
    checkOutput("bp_drain2_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_count",   {24'd0, ovf_count}, 32'd5);

    // Streaming: one result per cycle, each visible right after its accepting edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h00000100 + i;
      @(posedge clk); #1;
      checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_data",  {16'd0, out_data},  32'h0100 + i);
      checkOutput("stream_ready", {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("stream_done", {31'd0, out_valid}, 32'd0);

    // Counter edges
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    checkOutput("cnt_cleared", {24'd0, ovf_count}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h00010000;
    sat_mode = 1'b1;
    for (int i = 1; i <= 259; i++) begin
      @(posedge clk); #1;
      if (i == 254) checkOutput("cnt_254", {24'd0, ovf_count}, 32'd254);
      if (i == 256) checkOutput("cnt_256", {24'd0, ovf_count}, 32'd255);
    end
    checkOutput("cnt_stays", {24'd0, ovf_count}, 32'd255);
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    in_valid  = 1'b0;
    checkOutput("cnt_clr_prio", {24'd0, ovf_count}, 32'd0);
    @(posedge clk); #1;
    checkOutput("cnt_clr_valid", {31'd0, out_valid}, 32'd0);

    // Async reset with two entries buffered
    out_ready = 1'b0;
    applyStimulus(32'h00010000, 1'b1);
    applyStimulus(32'hFFF00000, 1'b0);
    checkOutput("ar_full",  {31'd0, in_ready},  32'd0);
    checkOutput("ar_count", {24'd0, ovf_count}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ar_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("ar_ovf_count", {24'd0, ovf_count}, 32'd0);
    checkOutput("ar_out_data",  {16'd0, out_data},  32'h0);
    checkOutput("ar_out_ovf",   {31'd0, out_ovf},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_empty", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'h00000055, 1'b0);
    checkOutput("post_rst_data", {16'd0, out_data}, 32'h0055);
    checkOutput("post_rst_ovf",  {31'd0, out_ovf},  32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
